// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// Bus-level encodings keep ACK/NACK and R/W comparisons readable in the FSM.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_ADDR     = 3'd2,
      ST_ADDR_ACK = 3'd3,
      ST_DATA     = 3'd4,
      ST_DATA_ACK = 3'd5,
      ST_STOP     = 3'd6
   } i2c_state_e;

   typedef logic [1:0] quarter_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: one-cycle tick at the last clk of each quarter
// plus a free-running 2-bit quarter index; clear_i restarts both at zero.
module i2c_qtick_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     clear_i,
   output logic     tick_o,
   output quarter_t q_o
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   quarter_t      q_q, q_d;

   assign tick_o = (cnt_q == CW'(CLK_DIV - 1));
   assign q_o    = q_q;

   always_comb begin
      cnt_d = cnt_q;
      q_d   = q_q;
      if (clear_i) begin
         cnt_d = '0;
         q_d   = '0;
      end else if (tick_o) begin
         cnt_d = '0;
         q_d   = q_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         q_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+RW, ACK, one data byte, ACK/NACK, STOP.
// Bus outputs are decoded from registered state so reset forces them idle at once.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic       rsp_nack,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       scl,
   output logic       sda_o,
   output logic       sda_oe,
   input  logic       sda_i,
   output i2c_state_e dbg_state
);

   i2c_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] addr_byte_q, addr_byte_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       nack_q, nack_d;
   logic       rsp_valid_q, rsp_valid_d;

   logic       tick;
   quarter_t   q;
   logic       accept;
   logic       bit_end;
   logic       sample;

   // Command handshake: a transfer happens in any cycle where cmd_valid and
   // cmd_ready are both high; cmd_ready is high exactly while IDLE, and the
   // command fields are captured in that cycle and never looked at again.
   assign accept    = cmd_valid && (state_q == ST_IDLE);
   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_nack  = nack_q;
   assign rsp_rdata = rdata_q;
   assign dbg_state = state_q;
   assign bit_end   = tick && (q == 2'd3);
   assign sample    = tick && (q == 2'd2);

   i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
      .clk     (clk),
      .rst     (rst),
      .clear_i (accept),
      .tick_o  (tick),
      .q_o     (q)
   );

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      addr_byte_d = addr_byte_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      nack_d      = nack_q;
      rsp_valid_d = 1'b0;
      scl         = 1'b1;
      sda_oe      = 1'b0;
      sda_o       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d     = ST_START;
               addr_byte_d = {cmd_addr, cmd_rw};
               wdata_d     = cmd_wdata;
               rdata_d     = '0;
               nack_d      = 1'b0;
            end
         end
         ST_START: begin
            sda_oe = q[1];
            if (bit_end) begin
               state_d   = ST_ADDR;
               bit_cnt_d = 3'd7;
            end
         end
         ST_ADDR: begin
            scl    = q[1];
            sda_oe = 1'b1;
            sda_o  = addr_byte_q[bit_cnt_q];
            if (bit_end) begin
               if (bit_cnt_q == 3'd0) state_d = ST_ADDR_ACK;
               else bit_cnt_d = bit_cnt_q - 3'd1;
            end
         end
         ST_ADDR_ACK: begin
            scl = q[1];
            if (sample && (sda_i != I2C_ACK)) nack_d = 1'b1;
            if (bit_end) begin
               state_d   = nack_q ? ST_STOP : ST_DATA;
               bit_cnt_d = 3'd7;
            end
         end
         ST_DATA: begin
            scl = q[1];
            // Read data is shifted in MSB first; the master only drives on writes.
            if (addr_byte_q[0] == RW_READ) begin
               if (sample) rdata_d = {rdata_q[6:0], sda_i};
            end else begin
               sda_oe = 1'b1;
               sda_o  = wdata_q[bit_cnt_q];
            end
            if (bit_end) begin
               if (bit_cnt_q == 3'd0) state_d = ST_DATA_ACK;
               else bit_cnt_d = bit_cnt_q - 3'd1;
            end
         end
         ST_DATA_ACK: begin
            scl = q[1];
            if (sample && (addr_byte_q[0] == RW_WRITE) && (sda_i == I2C_NACK)) nack_d = 1'b1;
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            scl = q[1];
            if (q != 2'd3) sda_oe = 1'b1;
            if (bit_end) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         addr_byte_q <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         nack_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_byte_q <= addr_byte_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         nack_q      <= nack_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Single-byte I2C bus master that feeds the memory controller's slave port on the memory subsystem bus.
- Accepts one command per transaction: 7-bit target address, R/W, write byte.
- Generates the bit-level SCL/SDA sequence: START, address+RW, ACK, data byte, ACK/NACK, STOP.
- Returns the ACK status and any read byte to the requesting logic.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period; legal range >= 2. SCL period is 4*CLK_DIV clocks.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high when the block can accept a command
cmd_rw  input  1  1 = read, 0 = write
cmd_addr  input  7  target slave address
cmd_wdata  input  8  byte to write; ignored on read
rsp_valid  output  1  one-cycle pulse when the transaction completes
rsp_nack  output  1  1 = address or data phase was NACKed; valid with rsp_valid
rsp_rdata  output  8  read byte; valid with rsp_valid when cmd_rw=1 and rsp_nack=0
busy  output  1  high in any state other than IDLE
scl  output  1  bus clock, push-pull
sda_o  output  1  SDA drive value; only meaningful when sda_oe=1
sda_oe  output  1  1 = drive sda_o onto SDA, 0 = release (pull-up gives 1)
sda_i  input  1  sampled SDA line

Behaviour:
- Reset values: scl=1, sda_oe=0, sda_o=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_nack=0, rsp_rdata=0, state=IDLE, counters=0.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronously). No rsp_valid is issued, and no STOP is generated.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE).
  - On acceptance, cmd_* fields are registered; later changes to the inputs are ignored.
  - cmd_valid while busy has no effect.
- Quarter ticks: a divider counts 0..CLK_DIV-1 and a 2-bit quarter index q advances on each wrap. Every bit time is 4 quarters. The divider restarts at 0 on acceptance.
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- START (1 bit time):
  - q0-q1: scl=1, SDA released.
  - q2-q3: scl=1, sda_oe=1, sda_o=0.
- Generic bit (ADDR, ADDR_ACK, DATA, DATA_ACK):
  - q0-q1: scl=0; SDA changes only at the start of q0.
  - q2-q3: scl=1, SDA stable.
  - sda_i is sampled in the last clk of q2.
- ADDR: 8 bits, MSB first: {cmd_addr, cmd_rw}. Bit counter 7 down to 0, then go to ADDR_ACK.
- ADDR_ACK: SDA released. Sampled 0 -> DATA. Sampled 1 -> record nack=1, go to STOP.
- DATA:
  - Write: drive cmd_wdata MSB first.
  - Read: SDA released; shift sampled bits MSB first into rdata.
- DATA_ACK:
  - Write: SDA released; sampled 1 sets nack=1.
  - Read: master releases SDA (NACK, last byte); nack stays 0.
  - Then go to STOP.
- STOP (1 bit time):
  - q0-q1: scl=0, sda_oe=1, sda_o=0.
  - q2: scl=1, SDA low.
  - q3: scl=1, SDA released (rising SDA with SCL high).
- Completion: at the end of STOP q3, state goes to IDLE. rsp_valid pulses for exactly 1 cycle in the first IDLE cycle, with rsp_nack and rsp_rdata stable from that cycle until the next acceptance.
- Latency: acceptance in cycle N gives rsp_valid in cycle N+1+80*CLK_DIV (20 bit times). An address NACK gives N+1+44*CLK_DIV (11 bit times).
- Back-to-back: a command may be accepted in the same cycle rsp_valid is high.
- SCL changes only at quarter boundaries. Between q1 and q2 of any bit, SDA never changes while scl=1, except the START/STOP edges.

Decomposition:
- Package i2c_pkg holds:
  - state enum i2c_state_e.
  - quarter typedef (2-bit).
  - I2C_ACK=1'b0 and I2C_NACK=1'b1.
  - RW_READ=1'b1 and RW_WRITE=1'b0.
- Sub-module i2c_qtick_gen: divider producing a one-cycle tick at each quarter end plus the q index; clear input on acceptance.

Test Plan:
1. Write addr 0x50, wdata 0xAB, bench slave ACKs both phases -> SDA shows START, 0xA0, ACK, 0xAB, ACK, STOP. rsp_nack=0. rsp_valid exactly 80*CLK_DIV+1 cycles after acceptance.
2. Write addr 0x21, sda_i held 1 -> STOP directly after the 9th clock. No data bits on the bus. rsp_nack=1. Latency 44*CLK_DIV+1.
3. Read addr 0x50, slave ACKs then drives 0x5A -> address byte 0xA1, SDA released on the 18th clock, rsp_rdata=0x5A, rsp_nack=0.
4. Write 0x33 to addr 0x10, data phase NACK -> full 20 bit times, rsp_nack=1. A protocol checker confirms no SDA change while SCL is high except START/STOP.
5. cmd_valid held high with two commands -> second accepted in the rsp_valid cycle; one idle-free START follows. cmd_valid with changed fields while busy does not alter the bus.
6. Assert rst during DATA bit 3 -> same cycle: scl=1, sda_oe=0, busy=0, no rsp_valid. A following write of 0x5A to addr 0x50 completes correctly.
